// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receive-chain definitions: SIGNAL-field rate codes, code-rate
// enum, per-rate coded/data bits per OFDM symbol, depuncturer FSM states.
// No ports; imported by the depuncturer and its rate lookup.
package ofdm_rx_pkg;

    // 4-bit SIGNAL-field rate codes
    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    typedef enum logic [1:0] {
        CR12 = 2'd0,
        CR23 = 2'd1,
        CR34 = 2'd2
    } code_rate_e;

    // Coded bits per OFDM symbol, by modulation
    localparam logic [8:0] NCBPS_BPSK  = 9'd48;
    localparam logic [8:0] NCBPS_QPSK  = 9'd96;
    localparam logic [8:0] NCBPS_16QAM = 9'd192;
    localparam logic [8:0] NCBPS_64QAM = 9'd288;

    // Data bits per OFDM symbol, by rate
    localparam logic [8:0] NDBPS_6M  = 9'd24;
    localparam logic [8:0] NDBPS_9M  = 9'd36;
    localparam logic [8:0] NDBPS_12M = 9'd48;
    localparam logic [8:0] NDBPS_18M = 9'd72;
    localparam logic [8:0] NDBPS_24M = 9'd96;
    localparam logic [8:0] NDBPS_36M = 9'd144;
    localparam logic [8:0] NDBPS_48M = 9'd192;
    localparam logic [8:0] NDBPS_54M = 9'd216;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } dp_state_e;

    // Highest phase of the puncturing pattern (pattern period - 1)
    function automatic logic [1:0] last_phase(input code_rate_e cr);
        case (cr)
            CR23:    last_phase = 2'd2;
            CR34:    last_phase = 2'd3;
            default: last_phase = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/depunct_rate_lut.sv
// Purpose: decode the SIGNAL-field rate code into code rate, Ncbps and legality.
// Latency: combinational. Backpressure: none (pure decode).
// Ports: rate_i (4b code) -> cr_o (code_rate_e as 2b), ncbps_o (9b), legal_o.
module depunct_rate_lut
    import ofdm_rx_pkg::*;
(
    input  logic [3:0] rate_i,
    output logic [1:0] cr_o,
    output logic [8:0] ncbps_o,
    output logic       legal_o
);

    always_comb begin
        cr_o    = CR12;
        ncbps_o = NCBPS_BPSK;
        legal_o = 1'b1;
        case (rate_i)
            RATE_6M:  begin cr_o = CR12; ncbps_o = NCBPS_BPSK;  end
            RATE_9M:  begin cr_o = CR34; ncbps_o = NCBPS_BPSK;  end
            RATE_12M: begin cr_o = CR12; ncbps_o = NCBPS_QPSK;  end
            RATE_18M: begin cr_o = CR34; ncbps_o = NCBPS_QPSK;  end
            RATE_24M: begin cr_o = CR12; ncbps_o = NCBPS_16QAM; end
            RATE_36M: begin cr_o = CR34; ncbps_o = NCBPS_16QAM; end
            RATE_48M: begin cr_o = CR23; ncbps_o = NCBPS_64QAM; end
            RATE_54M: begin cr_o = CR34; ncbps_o = NCBPS_64QAM; end
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/depuncturer.sv
// Purpose: rebuild the rate-1/2 (A,B) pair stream from the punctured serial
//   bit stream, marking re-inserted positions as erasures; flags symbol end.
// Latency: 1 cycle from accepted bit to out_valid. Backpressure: none; at most
//   one pair per input bit, so the output never needs to stall the input.
// Ports: Clk, Reset (async, active-low), Start (sync clear when low), Rate,
//   x/x_valid in; a/b/ea/eb/out_valid/sym_end pair out; rate_err status.
module depuncturer
    import ofdm_rx_pkg::*;
#(
    parameter logic ERASE_VAL = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] Rate,
    input  logic       x,
    input  logic       x_valid,
    output logic       a,
    output logic       b,
    output logic       ea,
    output logic       eb,
    output logic       out_valid,
    output logic       sym_end,
    output logic       rate_err
);

    logic [1:0] lut_cr;
    logic [8:0] lut_ncbps;
    logic       lut_legal;

    depunct_rate_lut u_lut (
        .rate_i  (Rate),
        .cr_o    (lut_cr),
        .ncbps_o (lut_ncbps),
        .legal_o (lut_legal)
    );

    dp_state_e  state_q;
    code_rate_e cr_q;
    logic [8:0] ncbps_q;
    logic [8:0] cnt_q, cnt_d;
    logic [1:0] ph_q, ph_d;
    logic       hold_q;
    logic       a_q, b_q, ea_q, eb_q;
    logic       out_valid_q, sym_end_q, rate_err_q;

    logic       accept;
    logic       cnt_wrap;
    logic       emit_d;
    logic       a_d, b_d, ea_d, eb_d;

    always_comb begin
        accept   = (state_q == ST_RUN) && x_valid;
        cnt_wrap = (cnt_q == ncbps_q - 9'd1);
        cnt_d    = cnt_wrap ? 9'd0 : cnt_q + 9'd1;
        ph_d     = (ph_q == last_phase(cr_q)) ? 2'd0 : ph_q + 2'd1;

        emit_d = 1'b0;
        a_d    = a_q;
        b_d    = b_q;
        ea_d   = ea_q;
        eb_d   = eb_q;
        // Phase 0 only captures A; later phases each complete one pair.
        case (ph_q)
            2'd1: begin emit_d = 1'b1; a_d = hold_q;    b_d = x;         ea_d = 1'b0; eb_d = 1'b0; end
            2'd2: begin emit_d = 1'b1; a_d = x;         b_d = ERASE_VAL; ea_d = 1'b0; eb_d = 1'b1; end
            2'd3: begin emit_d = 1'b1; a_d = ERASE_VAL; b_d = x;         ea_d = 1'b1; eb_d = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cr_q        <= CR12;
            ncbps_q     <= 9'd0;
            cnt_q       <= 9'd0;
            ph_q        <= 2'd0;
            hold_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            ea_q        <= 1'b0;
            eb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sym_end_q   <= 1'b0;
            rate_err_q  <= 1'b0;
        end else if (!Start) begin
            // Synchronous packet abort: any half-built pair is dropped.
            state_q     <= ST_IDLE;
            cr_q        <= CR12;
            ncbps_q     <= 9'd0;
            cnt_q       <= 9'd0;
            ph_q        <= 2'd0;
            hold_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            ea_q        <= 1'b0;
            eb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sym_end_q   <= 1'b0;
            rate_err_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            sym_end_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Rate is sampled only here; later changes are ignored.
                    cnt_q <= 9'd0;
                    ph_q  <= 2'd0;
                    if (lut_legal) begin
                        state_q <= ST_RUN;
                        cr_q    <= code_rate_e'(lut_cr);
                        ncbps_q <= lut_ncbps;
                    end else begin
                        state_q    <= ST_ERR;
                        rate_err_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        ph_q  <= ph_d;
                        cnt_q <= cnt_d;
                        if (ph_q == 2'd0) begin
                            hold_q <= x;
                        end
                        if (emit_d) begin
                            a_q         <= a_d;
                            b_q         <= b_d;
                            ea_q        <= ea_d;
                            eb_q        <= eb_d;
                            out_valid_q <= 1'b1;
                            sym_end_q   <= cnt_wrap;
                        end
                    end
                end
                default: ; // ST_ERR: hold until Start drops
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ea        = ea_q;
    assign eb        = eb_q;
    assign out_valid = out_valid_q;
    assign sym_end   = sym_end_q;
    assign rate_err  = rate_err_q;

endmodule

// File: tb/tb_depuncturer.sv
module tb_depuncturer;

    localparam logic ERASE = 1'b0;

    logic       Clk = 1'b0;
    logic       Reset, Start, x, x_valid;
    logic [3:0] Rate;
    logic       a, b, ea, eb, out_valid, sym_end, rate_err;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_abee = 4'b0;   // expected held {a,b,ea,eb}

    depuncturer #(.ERASE_VAL(ERASE)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Rate(Rate), .x(x), .x_valid(x_valid),
        .a(a), .b(b), .ea(ea), .eb(eb), .out_valid(out_valid), .sym_end(sym_end),
        .rate_err(rate_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rate table: legality, pattern period, Ncbps, Ndbps
    task automatic rate_info(input logic [3:0] r, output bit legal, output int per,
                             output int ncbps, output int ndbps);
        legal = 1'b1;
        case (r)
            4'b1101: begin per = 2; ncbps = 48;  ndbps = 24;  end
            4'b1111: begin per = 4; ncbps = 48;  ndbps = 36;  end
            4'b0101: begin per = 2; ncbps = 96;  ndbps = 48;  end
            4'b0111: begin per = 4; ncbps = 96;  ndbps = 72;  end
            4'b1001: begin per = 2; ncbps = 192; ndbps = 96;  end
            4'b1011: begin per = 4; ncbps = 192; ndbps = 144; end
            4'b0001: begin per = 3; ncbps = 288; ndbps = 192; end
            4'b0011: begin per = 4; ncbps = 288; ndbps = 216; end
            default: begin legal = 1'b0; per = 2; ncbps = 48; ndbps = 0; end
        endcase
    endtask

    // Runs one packet from a negedge. plen==0 -> random bits, else pattern
    // pat (MSB first, plen bits). vmode: 0 continuous, 1 toggle, 2 random.
    task automatic run_pkt(input logic [3:0] r, input int nbits, input logic [3:0] pat,
                           input int plen, input int vmode, input bit rand_rate,
                           output int npairs, output int nsym);
        bit   legal;
        int   per, ncbps, ndbps;
        logic bits[$];
        int   n, k, cyc, p, g;
        logic v, xb;
        bit   ev, es;
        rate_info(r, legal, per, ncbps, ndbps);
        npairs = 0; nsym = 0; n = 0; k = 0; cyc = 0;
        Start = 1'b1; Rate = r; x_valid = 1'b0; x = 1'b0;
        @(negedge Clk);
        check("rate_err_latch", rate_err, !legal);
        check("ov_latch", out_valid, 1'b0);
        while (k < nbits) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            xb = (plen == 0) ? 1'($urandom_range(0, 1)) : pat[plen - 1 - (k % plen)];
            x = xb; x_valid = v;
            if (rand_rate) Rate = 4'($urandom_range(0, 15));
            @(negedge Clk);
            cyc++;
            ev = 1'b0; es = 1'b0;
            if (v) begin
                k++;
                if (legal) begin
                    bits.push_back(xb);
                    p = n % per;
                    g = n - p;
                    case (p)
                        1: begin ev = 1'b1; exp_abee = {bits[g], bits[g+1], 2'b00}; end
                        2: begin ev = 1'b1; exp_abee = {bits[g+2], ERASE, 2'b01}; end
                        3: begin ev = 1'b1; exp_abee = {ERASE, bits[g+3], 2'b10}; end
                        default: ;
                    endcase
                    es = ev && (n % ncbps == ncbps - 1);
                    n++;
                end
            end
            check("out_valid", out_valid, ev);
            check("sym_end", sym_end, es);
            check("pair_abee", {a, b, ea, eb}, exp_abee);
            check("rate_err", rate_err, !legal);
            if (out_valid === 1'b1) npairs++;
            if (sym_end === 1'b1) begin
                nsym++;
                check("ph_at_wrap", dut.ph_q, 0);
            end
            if (cyc > 20000) begin
                check("timeout_bits", k, nbits);
                break;
            end
        end
        x_valid = 1'b0;
        @(negedge Clk);
        check("quiet_ov", out_valid, 1'b0);
        check("quiet_hold", {a, b, ea, eb}, exp_abee);
    endtask

    task automatic end_pkt();
        Start = 1'b0; x_valid = 1'b0;
        @(negedge Clk);
        exp_abee = 4'b0;
        check("start_clear", {a, b, ea, eb, out_valid, sym_end, rate_err}, 0);
    endtask

    initial begin
        int np, ns, mult, per, ncbps, ndbps;
        bit legal;
        logic [3:0] r;
        logic [3:0] legal_rates [8];
        legal_rates = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};

        Reset = 1'b0; Start = 1'b0; Rate = 4'b0; x = 1'b0; x_valid = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_state", {a, b, ea, eb, out_valid, sym_end, rate_err}, 0);
        Reset = 1'b1;
        @(negedge Clk);

        // R=1/2, 48 bits of 1010...
        run_pkt(4'b1101, 48, 4'b0010, 2, 0, 0, np, ns);
        check("r6_pairs", np, 24);
        check("r6_symend", ns, 1);
        end_pkt();

        // R=3/4 at 288, bits 1101...
        run_pkt(4'b0011, 288, 4'b1101, 4, 0, 0, np, ns);
        check("r54_pairs", np, 216);
        check("r54_symend", ns, 1);
        end_pkt();

        // R=2/3, bits 101 x96
        run_pkt(4'b0001, 288, 4'b0101, 3, 0, 0, np, ns);
        check("r48_pairs", np, 192);
        check("r48_symend", ns, 1);
        end_pkt();

        // R=3/4 at 96 with x_valid toggling
        run_pkt(4'b0111, 96, 4'b0, 0, 1, 0, np, ns);
        check("r18_gap_pairs", np, 72);
        check("r18_gap_symend", ns, 1);
        end_pkt();

        // Abort after 5 bits, restart at another rate
        run_pkt(4'b1001, 5, 4'b0, 0, 0, 0, np, ns);
        check("abort_pairs", np, 2);
        end_pkt();
        run_pkt(4'b0101, 96, 4'b0, 0, 0, 0, np, ns);
        check("restart_pairs", np, 48);
        check("restart_symend", ns, 1);
        end_pkt();

        // Asynchronous reset mid-symbol: outputs drop without a clock edge
        run_pkt(4'b0011, 10, 4'b1101, 4, 0, 0, np, ns);
        check("pre_reset_pairs", np, 7);
        #1;
        Reset = 1'b0;
        #1;
        check("async_reset", {a, b, ea, eb, out_valid, sym_end, rate_err}, 0);
        @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b1;
        exp_abee = 4'b0;
        @(negedge Clk);
        check("post_reset", {a, b, ea, eb, out_valid, sym_end, rate_err}, 0);

        // Illegal rate
        run_pkt(4'b0000, 100, 4'b0, 0, 0, 0, np, ns);
        check("err_pairs", np, 0);
        end_pkt();

        // Random legal rates, random gaps, Rate wiggling mid-packet
        for (int i = 0; i < 6; i++) begin
            r = legal_rates[$urandom_range(0, 7)];
            rate_info(r, legal, per, ncbps, ndbps);
            mult = $urandom_range(1, 2);
            run_pkt(r, ncbps * mult, 4'b0, 0, 2, 1, np, ns);
            check("rand_pairs", np, ndbps * mult);
            check("rand_symend", ns, mult);
            end_pkt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
